// File: rtl/msx_mouse_port.sv
// msx_mouse_port: shares one MSX general-purpose port between a digital
// joystick and a PS/2 mouse, serving the 4-nibble MSX mouse read protocol.
// Build option: define MOUSE_ACCUM_EN to accumulate motion with saturation
// between host reads; undefined, each packet overwrites the pending motion.
module msx_mouse_port #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       mouse_strobe,
    input  logic [8:0] mouse_dx,
    input  logic [8:0] mouse_dy,
    input  logic [1:0] mouse_btn,
    input  logic [5:0] joy_n,
    input  logic       msx_str,
    output logic [5:0] port_out,
    output logic       mouse_active
);

    localparam int unsigned TIMER_W = 18;
    localparam int unsigned ACC_W   = 8;
    localparam int unsigned SUM_W   = 10;

    typedef enum logic [1:0] {
        N0 = 2'd0,
        N1 = 2'd1,
        N2 = 2'd2,
        N3 = 2'd3
    } nib_state_t;

    nib_state_t         state, state_nx;
    logic [ACC_W-1:0]   acc_x, acc_y, acc_x_nx, acc_y_nx;
    logic [ACC_W-1:0]   snap_x, snap_y, snap_x_nx, snap_y_nx;
    logic [TIMER_W-1:0] timer, timer_nx;
    logic               str_q;
    logic               active_nx;
    logic [5:0]         port_nx;
    logic [3:0]         nib;
    logic               str_tgl;
    logic               joy_busy;
    logic               drop;
    logic               adv;

    // Clamp a 10-bit two's complement value to the signed 8-bit range.
    function automatic logic [ACC_W-1:0] sat8(input logic [SUM_W-1:0] v);
        logic [ACC_W-1:0] r;
        if (!v[9] && (v[8:7] != 2'b00)) begin
            r = 8'h7F;
        end else if (v[9] && (v[8:7] != 2'b11)) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    // Next-state: ownership, nibble sequencing, motion capture, timeout.
    always_comb begin
        state_nx  = state;
        acc_x_nx  = acc_x;
        acc_y_nx  = acc_y;
        snap_x_nx = snap_x;
        snap_y_nx = snap_y;
        timer_nx  = timer;
        nib       = port_out[3:0];

        str_tgl   = (msx_str != str_q);
        joy_busy  = (joy_n != 6'h3F);
        drop      = mouse_active && joy_busy;
        adv       = mouse_active && str_tgl && !drop;
        active_nx = joy_busy ? 1'b0 : (mouse_strobe ? 1'b1 : mouse_active);

        if (adv) begin
            timer_nx = TIMER_W'(TIMEOUT_CYCLES);
            case (state)
                N0: begin
                    nib       = acc_x[7:4];
                    snap_x_nx = acc_x;
                    snap_y_nx = acc_y;
                    acc_x_nx  = '0;
                    acc_y_nx  = '0;
                    state_nx  = N1;
                end
                N1: begin
                    nib      = snap_x[3:0];
                    state_nx = N2;
                end
                N2: begin
                    nib      = snap_y[7:4];
                    state_nx = N3;
                end
                N3: begin
                    nib      = snap_y[3:0];
                    state_nx = N0;
                end
            endcase
        end else if (timer != '0) begin
            timer_nx = timer - TIMER_W'(1);
            if (timer == TIMER_W'(1)) begin
                state_nx = N0;
            end
        end

        // A packet in the snapshot cycle lands on the freshly cleared accumulator.
        if (mouse_strobe) begin
`ifdef MOUSE_ACCUM_EN
            acc_x_nx = sat8(SUM_W'({{2{acc_x_nx[7]}}, acc_x_nx}) + SUM_W'({mouse_dx[8], mouse_dx}));
            acc_y_nx = sat8(SUM_W'({{2{acc_y_nx[7]}}, acc_y_nx}) + SUM_W'({mouse_dy[8], mouse_dy}));
`else
            acc_x_nx = sat8(SUM_W'({mouse_dx[8], mouse_dx}));
            acc_y_nx = sat8(SUM_W'({mouse_dy[8], mouse_dy}));
`endif
        end

        // Losing the port discards all mouse context.
        if (drop) begin
            state_nx  = N0;
            acc_x_nx  = '0;
            acc_y_nx  = '0;
            snap_x_nx = '0;
            snap_y_nx = '0;
            timer_nx  = '0;
        end

        port_nx = mouse_active ? {~mouse_btn, nib} : joy_n;
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= N0;
            acc_x        <= '0;
            acc_y        <= '0;
            snap_x       <= '0;
            snap_y       <= '0;
            timer        <= '0;
            str_q        <= 1'b0;
            mouse_active <= 1'b0;
            port_out     <= 6'h3F;
        end else begin
            state        <= state_nx;
            acc_x        <= acc_x_nx;
            acc_y        <= acc_y_nx;
            snap_x       <= snap_x_nx;
            snap_y       <= snap_y_nx;
            timer        <= timer_nx;
            str_q        <= msx_str;
            mouse_active <= active_nx;
            port_out     <= port_nx;
        end
    end

endmodule

// File: tb/tb_msx_mouse_port.sv
// Testbench for msx_mouse_port: directed protocol scenarios plus a random
// phase, all checked against a behavioural model of the port.
module tb_msx_mouse_port;

    localparam int TO = 20;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       mouse_strobe = 1'b0;
    logic [8:0] mouse_dx = '0;
    logic [8:0] mouse_dy = '0;
    logic [1:0] mouse_btn = '0;
    logic [5:0] joy_n = 6'h3F;
    logic       msx_str = 1'b0;
    logic [5:0] port_out;
    logic       mouse_active;

    int checks = 0;
    int errors = 0;

    // model state
    int         m_acc_x, m_acc_y, m_snap_x, m_snap_y, m_idx, m_timer;
    logic       m_str_q, m_active;
    logic [5:0] m_port;

    msx_mouse_port #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .mouse_strobe (mouse_strobe),
        .mouse_dx     (mouse_dx),
        .mouse_dy     (mouse_dy),
        .mouse_btn    (mouse_btn),
        .joy_n        (joy_n),
        .msx_str      (msx_str),
        .port_out     (port_out),
        .mouse_active (mouse_active)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_reset();
        m_acc_x = 0; m_acc_y = 0; m_snap_x = 0; m_snap_y = 0;
        m_idx = 0; m_timer = 0; m_str_q = 1'b0; m_active = 1'b0;
        m_port = 6'h3F;
    endtask

    // One clock of the port behaviour, from the inputs present before the edge.
    task automatic model_step();
        int   dx, dy, nib;
        logic tgl, joy, drop, adv, nxt_active;
        dx   = int'($signed(mouse_dx));
        dy   = int'($signed(mouse_dy));
        tgl  = (msx_str != m_str_q);
        joy  = (joy_n != 6'h3F);
        drop = m_active && joy;
        adv  = m_active && tgl && !drop;
        nib  = int'(m_port[3:0]);
        nxt_active = joy ? 1'b0 : (mouse_strobe ? 1'b1 : m_active);
        if (adv) begin
            if (m_idx == 0) begin
                nib = (m_acc_x & 255) / 16;
                m_snap_x = m_acc_x; m_snap_y = m_acc_y;
                m_acc_x = 0; m_acc_y = 0;
            end else if (m_idx == 1) nib = m_snap_x & 15;
            else if (m_idx == 2)     nib = (m_snap_y & 255) / 16;
            else                     nib = m_snap_y & 15;
            m_idx = (m_idx + 1) % 4;
            m_timer = TO;
        end else if (m_timer > 0) begin
            m_timer--;
            if (m_timer == 0) m_idx = 0;
        end
        if (mouse_strobe) begin
`ifdef MOUSE_ACCUM_EN
            m_acc_x = sat(m_acc_x + dx); m_acc_y = sat(m_acc_y + dy);
`else
            m_acc_x = sat(dx); m_acc_y = sat(dy);
`endif
        end
        if (drop) begin
            m_idx = 0; m_acc_x = 0; m_acc_y = 0; m_snap_x = 0; m_snap_y = 0; m_timer = 0;
        end
        m_port   = m_active ? {~mouse_btn, 4'(nib)} : joy_n;
        m_active = nxt_active;
        m_str_q  = msx_str;
    endtask

    // Advance one clock and compare both outputs against the model.
    task automatic tick();
        model_step();
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("port_out", 8'(port_out), 8'(m_port));
        chk("mouse_active", 8'(mouse_active), 8'(m_active));
    endtask

    task automatic packet(input logic [8:0] dx, input logic [8:0] dy, input logic [1:0] btn);
        mouse_strobe = 1'b1; mouse_dx = dx; mouse_dy = dy; mouse_btn = btn;
        tick();
        mouse_strobe = 1'b0; mouse_dx = '0; mouse_dy = '0;
        tick();
    endtask

    task automatic toggle(output logic [3:0] nib);
        msx_str = ~msx_str;
        tick();
        nib = port_out[3:0];
    endtask

    task automatic read4(output logic [15:0] word);
        logic [3:0] n;
        for (int i = 0; i < 4; i++) begin
            toggle(n);
            word = {word[11:0], n};
        end
    endtask

    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("reset_port_out", 8'(port_out), 8'h3F);
        chk("reset_mouse_active", 8'(mouse_active), 8'h00);
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] w;
        logic [3:0]  n;
        model_reset();

        // reset, joystick pass-through
        #12;
        chk("rst_port_out", 8'(port_out), 8'h3F);
        chk("rst_mouse_active", 8'(mouse_active), 8'h00);
        @(negedge clk_sys);
        reset_n = 1'b1;
        tick();
        joy_n = 6'h3E;
        tick();
        chk("joy_passthru", 8'(port_out), 8'h3E);
        joy_n = 6'h3F;
        tick();

        // single packet, two reads
        packet(9'd5, 9'h1FD, 2'b01);
        chk("active_after_packet", 8'(mouse_active), 8'h01);
        read4(w);
        chk("read1", 8'(w[15:8]), 8'h05);
        chk("read1_lo", 8'(w[7:0]), 8'hFD);
        chk("buttons", 8'(port_out[5:4]), 8'h02);
        read4(w);
        chk("read2", 8'(w[15:8]), 8'h00);
        chk("read2_lo", 8'(w[7:0]), 8'h00);

        // accumulation / clamping
        for (int i = 0; i < 3; i++) packet(9'd100, 9'd0, 2'b00);
        read4(w);
`ifdef MOUSE_ACCUM_EN
        chk("x_clamp_pos", 8'(w[15:8]), 8'h7F);
`else
        chk("x_overwrite", 8'(w[15:8]), 8'h64);
`endif
        packet(9'h138, 9'd0, 2'b00);
        packet(9'h138, 9'd0, 2'b00);
        read4(w);
        chk("x_clamp_neg", 8'(w[15:8]), 8'h80);

        // timeout restart: two toggles, TO idle clocks, toggle -> N0
        packet(9'd0, 9'h060, 2'b00);
        toggle(n); toggle(n);
        mouse_strobe = 1'b1; mouse_dx = 9'h047; mouse_dy = '0;
        tick();
        mouse_strobe = 1'b0; mouse_dx = '0;
        repeat (TO - 1) tick();
        toggle(n);
        chk("timeout_restart", 8'(n), 8'h04);
        toggle(n); toggle(n); toggle(n);

        // toggle exactly at expiry advances
        packet(9'h012, 9'h060, 2'b00);
        toggle(n); toggle(n);
        repeat (TO - 1) tick();
        toggle(n);
        chk("expiry_toggle_wins", 8'(n), 8'h06);
        toggle(n);

        // joystick takeover at N2
        packet(9'h033, 9'h044, 2'b10);
        toggle(n); toggle(n);
        joy_n = 6'h3E;
        tick();
        chk("takeover_active", 8'(mouse_active), 8'h00);
        tick();
        chk("takeover_port", 8'(port_out), 8'h3E);
        joy_n = 6'h3F;
        tick();
        packet(9'h05A, 9'd0, 2'b00);
        toggle(n);
        chk("after_takeover_n0", 8'(n), 8'h05);
        toggle(n); toggle(n); toggle(n);

        // reset mid-read at N1
        packet(9'h0A7, 9'd1, 2'b11);
        toggle(n);
        async_reset();
        packet(9'h039, 9'd2, 2'b00);
        toggle(n);
        chk("post_reset_n0", 8'(n), 8'h03);

        // random phase
        for (int c = 0; c < 600; c++) begin
            mouse_strobe = ($urandom_range(3) == 0);
            if (mouse_strobe) begin
                mouse_dx  = 9'($urandom);
                mouse_dy  = 9'($urandom);
                mouse_btn = 2'($urandom);
            end
            if ($urandom_range(2) == 0) msx_str = ~msx_str;
            joy_n = ($urandom_range(59) == 0) ? 6'($urandom_range(62)) : 6'h3F;
            tick();
            if ($urandom_range(49) == 0) begin
                mouse_strobe = 1'b0; joy_n = 6'h3F;
                repeat (TO + int'($urandom_range(3)) - 2) tick();
            end
        end
        mouse_strobe = 1'b0; joy_n = 6'h3F;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msx_mouse_port.md
# msx_mouse_port

Controller that owns one MSX general-purpose joystick port and shares it between the digital joystick and a PS/2 mouse. It sequences the MSX mouse nibble protocol on strobe (pin 8) toggles, accumulates PS/2 motion between host reads, and switches port ownership automatically. It sits between the PS/2 mouse decoder / joystick sources and the `pJoyA`/`pJoyB` inputs of `emsx_top`, one instance per port.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 100000: idle clocks without a strobe toggle after which the nibble sequence restarts at nibble 0; range 2..262143.

Ports:
- `clk_sys` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mouse_strobe` in 1: one-cycle pulse; a new PS/2 packet is valid on `mouse_dx`/`mouse_dy`/`mouse_btn`.
- `mouse_dx` in 9: signed X delta, two's complement.
- `mouse_dy` in 9: signed Y delta, two's complement.
- `mouse_btn` in 2: [0] left, [1] right; 1 = pressed.
- `joy_n` in 6: joystick, active-low; [0] up, [1] down, [2] left, [3] right, [4] trigger A, [5] trigger B.
- `msx_str` in 1: port strobe from the PSG, synchronous to `clk_sys`.
- `port_out` out 6: value presented to the MSX port, same bit order as `joy_n`.
- `mouse_active` out 1: 1 = mouse owns the port.

## Operation
- Ownership:
  - `mouse_active` sets on `mouse_strobe`.
  - It clears on any cycle with `joy_n != 6'h3F`; joystick wins if both occur in one cycle.
  - A 1→0 transition forces nibble state to 0 and clears accumulators and snapshot.
- Joystick mode: `port_out` = `joy_n`, registered.
- Mouse mode:
  - `port_out[4]` = ~`mouse_btn[0]` and `port_out[5]` = ~`mouse_btn[1]`, registered every cycle.
  - `port_out[3:0]` = current nibble.
- Accumulation, on `mouse_strobe`:
  - `acc_x` = sat8(`acc_x` + `mouse_dx`) and `acc_y` = sat8(`acc_y` + `mouse_dy`).
  - sat8 computes at 10 bits and clamps to [-128, +127].
- Nibble FSM, states N0..N3, advances once per toggle (either edge) of `msx_str`:
  - Toggle in N0:
    - snapshot `snap_x`/`snap_y` ← `acc_x`/`acc_y`, then clear accumulators.
    - output `acc_x[7:4]`; go to N1.
    - If `mouse_strobe` occurs in the same cycle, the snapshot takes the pre-add value and the accumulator takes the new delta alone.
  - Toggle in N1: output `snap_x[3:0]`; go to N2.
  - Toggle in N2: output `snap_y[7:4]`; go to N3.
  - Toggle in N3: output `snap_y[3:0]`; go to N0.
  - Toggles in joystick mode are ignored; state stays N0.
- Timeout counter:
  - Loaded with `TIMEOUT_CYCLES` on every mouse-mode toggle; decrements while nonzero.
  - On the 1→0 step, state ← N0; `port_out[3:0]` holds its value.
  - A toggle in the expiry cycle wins: the FSM advances and the counter reloads.

## Timing
- Reset values: `port_out` = 6'h3F, `mouse_active` = 0, state N0, accumulators/snapshot/timeout = 0, strobe register = 0.
- Toggle detect: `msx_str` != `str_q`, evaluated at the same edge that updates `str_q`.
  - `port_out` shows the new nibble after the first rising edge that samples the changed `msx_str` (1-clock latency).
- `mouse_active` and the joystick-mode `port_out` update 1 clock after their cause.
- Ownership switch takes effect on `port_out` 1 clock after `mouse_active` changes.
- Back-to-back toggles on consecutive clocks each advance the FSM; none are dropped.
- Reset mid-sequence returns asynchronously to the reset values; the first toggle after release is treated as N0.

## Configuration
- `MOUSE_ACCUM_EN` defined: saturating accumulation as above.
- `MOUSE_ACCUM_EN` undefined: each `mouse_strobe` overwrites `acc_x`/`acc_y` with sat8(`mouse_dx`)/sat8(`mouse_dy`); prior motion is discarded. Snapshot and clear behaviour are unchanged.

## Test plan
- Reset with `joy_n` = 3F: `port_out` = 3F, `mouse_active` = 0. Drive `joy_n` = 3E: `port_out` = 3E one clock later.
- Single packet (dx = +5, dy = -3, btn = 01) then 4 `msx_str` toggles: nibbles 0,5,F,D; `port_out[5:4]` = 2'b10. A second read of 4 toggles gives 0,0,0,0.
- With `MOUSE_ACCUM_EN`, three packets of dx = +100: a read gives X = 7F (clamped). dx = -200 then -200: X = 80.
- Two toggles, then `TIMEOUT_CYCLES` idle clocks, then a toggle: the nibble is the X high nibble (restart at N0). A toggle exactly at expiry advances to N2's output instead.
- In mouse mode at N2, press joystick up (`joy_n` = 3E): `mouse_active` = 0 next clock, `port_out` = 3E. A following packet then toggle starts at N0.
- Assert `reset_n` low mid-read at N1: outputs return to reset values immediately. After release and a packet, the first toggle yields the X high nibble.
